// File: rtl/grid_tx_scheduler.sv
// Round-robin mover from per-channel grid RX FIFOs into their serial transmitters.
// Optional ack watchdog on the bus cycle: define GRID_SCHED_TIMEOUT_EN.
module grid_tx_scheduler #(
    parameter int NCHANNELS = 9,
    parameter int RDLAT     = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk57,
    input  logic                 rst,
    input  logic [NCHANNELS-1:0] fifo_nempty,
    input  logic [NCHANNELS-1:0] tx_empty,
    input  logic [NCHANNELS-1:0] tx_ack,
    output logic [NCHANNELS-1:0] fifo_rd,
    output logic [NCHANNELS-1:0] tx_cyc,
    output logic [NCHANNELS-1:0] tx_stb,
    output logic [NCHANNELS-1:0] tx_we,
    output logic [NCHANNELS-1:0] tx_cs,
    output logic                 busy,
    output logic [3:0]           cur_chan,
    output logic                 err_timeout
);

    // Handshake: a channel is offered a word only when its FIFO has data and its
    // transmitter buffer is empty; the bus cycle holds cyc/stb/we/cs until tx_ack
    // of the granted channel is sampled high on a clk57 edge.

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_BUS,
        S_DONE
    } state_t;

    localparam logic [NCHANNELS-1:0] ONE       = {{(NCHANNELS-1){1'b0}}, 1'b1};
    localparam logic [1:0]           WAIT_INIT = 2'(RDLAT - 1);
    localparam logic [3:0]           LAST_INIT = 4'(NCHANNELS - 1);

    state_t                 state_q;
    logic [3:0]             last_q;
    logic [3:0]             chan_q;
    logic [1:0]             wait_q;
    logic [NCHANNELS-1:0]   fifo_rd_q;
    logic [NCHANNELS-1:0]   tx_cyc_q;
    logic                   busy_q;

    logic [NCHANNELS-1:0]   req;
    logic                   grant_found_d;
    logic [3:0]             grant_idx_d;
    logic [4:0]             cand;

    // First requester strictly after the last granted index, wrapping modulo NCHANNELS.
    always_comb begin
        req           = fifo_nempty & tx_empty;
        grant_found_d = 1'b0;
        grant_idx_d   = 4'd0;
        cand          = 5'd0;
        for (int i = 1; i <= NCHANNELS; i++) begin
            cand = {1'b0, last_q} + 5'(i);
            if (cand >= 5'(NCHANNELS)) begin
                cand = cand - 5'(NCHANNELS);
            end
            if (!grant_found_d && req[cand[3:0]]) begin
                grant_found_d = 1'b1;
                grant_idx_d   = cand[3:0];
            end
        end
    end

`ifdef GRID_SCHED_TIMEOUT_EN
    localparam int             TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_q;
    logic          err_q;
`endif

    always_ff @(posedge clk57) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= LAST_INIT;
            chan_q    <= 4'd0;
            wait_q    <= 2'd0;
            fifo_rd_q <= '0;
            tx_cyc_q  <= '0;
            busy_q    <= 1'b0;
`ifdef GRID_SCHED_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            fifo_rd_q <= '0;
`ifdef GRID_SCHED_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (grant_found_d) begin
                        chan_q    <= grant_idx_d;
                        fifo_rd_q <= ONE << grant_idx_d;
                        busy_q    <= 1'b1;
                        state_q   <= S_RD;
                    end
                end
                S_RD: begin
                    wait_q  <= WAIT_INIT;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q == 2'd0) begin
                        tx_cyc_q <= ONE << chan_q;
                        state_q  <= S_BUS;
`ifdef GRID_SCHED_TIMEOUT_EN
                        tmo_q    <= '0;
`endif
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                S_BUS: begin
                    if (tx_ack[chan_q]) begin
                        tx_cyc_q <= '0;
                        state_q  <= S_DONE;
                    end
`ifdef GRID_SCHED_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        tx_cyc_q <= '0;
                        err_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    last_q  <= chan_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd  = fifo_rd_q;
    assign tx_cyc   = tx_cyc_q;
    assign tx_stb   = tx_cyc_q;
    assign tx_we    = tx_cyc_q;
    assign tx_cs    = tx_cyc_q;
    assign busy     = busy_q;
    assign cur_chan = chan_q;

`ifdef GRID_SCHED_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    // Without the watchdog a bus cycle waits for ack indefinitely.
    assign err_timeout = 1'b0;
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

endmodule

// File: tb/tb_grid_tx_scheduler.sv
// Self-checking bench for grid_tx_scheduler: directed table, corner sequences, random transfers.
module tb_grid_tx_scheduler;

    localparam int N     = 9;
    localparam int RDLAT = 1;
    localparam int TMO   = 8;

    logic         clk57 = 1'b0;
    logic         rst;
    logic [N-1:0] fifo_nempty, tx_empty, tx_ack;
    logic [N-1:0] fifo_rd, tx_cyc, tx_stb, tx_we, tx_cs;
    logic         busy;
    logic [3:0]   cur_chan;
    logic         err_timeout;

    grid_tx_scheduler #(.NCHANNELS(N), .RDLAT(RDLAT), .TIMEOUT(TMO)) dut (
        .clk57(clk57), .rst(rst),
        .fifo_nempty(fifo_nempty), .tx_empty(tx_empty), .tx_ack(tx_ack),
        .fifo_rd(fifo_rd), .tx_cyc(tx_cyc), .tx_stb(tx_stb), .tx_we(tx_we), .tx_cs(tx_cs),
        .busy(busy), .cur_chan(cur_chan), .err_timeout(err_timeout)
    );

    always #5 clk57 = ~clk57;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ref_last;
    int last_rd_cyc;
    logic [N-1:0] exp_q[$];

    always @(posedge clk57) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference rule: first requester after the last grant, modulo N.
    function automatic int ref_grant(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (last + i) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // Monitor: one-hot shape, strobe aliases, scoreboard of granted FIFO reads.
    always @(negedge clk57) begin
        if (!rst) begin
            chk("onehot_rd", {31'b0, $onehot0(fifo_rd)}, 1);
            chk("onehot_cyc", {31'b0, $onehot0(tx_cyc)}, 1);
            chk("stb_eq_cyc", tx_stb, tx_cyc);
            chk("we_eq_cyc", tx_we, tx_cyc);
            chk("cs_eq_cyc", tx_cs, tx_cyc);
            if (fifo_rd != '0) begin
                if (exp_q.size() == 0) chk("sb_unexpected_rd", fifo_rd, 0);
                else                   chk("sb_grant", fifo_rd, exp_q.pop_front());
            end
`ifndef GRID_SCHED_TIMEOUT_EN
            chk("err_tied0", err_timeout, 0);
`endif
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        fifo_nempty = '0;
        tx_empty    = '0;
        tx_ack      = '0;
        exp_q.delete();
        repeat (2) @(negedge clk57);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_tx_cyc", tx_cyc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_chan", cur_chan, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;
        ref_last = N - 1;
        @(negedge clk57);
    endtask

    // Entered and left at a negedge with the DUT idle. exp_g < 0 means no grant expected.
    task automatic xfer(input logic [N-1:0] ne, input logic [N-1:0] te, input int exp_g,
                        input int d, input int spur, input bit scramble);
        logic [N-1:0] oh;
        chk("idle_before", busy, 0);
        fifo_nempty = ne;
        tx_empty    = te;
        if (exp_g < 0) begin
            repeat (4) begin
                @(negedge clk57);
                chk("nogrant_busy", busy, 0);
                chk("nogrant_rd", fifo_rd, 0);
            end
            fifo_nempty = '0;
            tx_empty    = '0;
            return;
        end
        oh = N'(1) << exp_g;
        exp_q.push_back(oh);
        @(negedge clk57);
        chk("rd_pulse", fifo_rd, oh);
        chk("rd_busy", busy, 1);
        chk("rd_cur_chan", cur_chan, exp_g);
        chk("rd_no_cyc", tx_cyc, 0);
        last_rd_cyc = cyc;
        if (scramble) begin
            fifo_nempty = N'($urandom);
            tx_empty    = N'($urandom);
        end
        repeat (RDLAT) begin
            @(negedge clk57);
            chk("wait_rd", fifo_rd, 0);
            chk("wait_cyc", tx_cyc, 0);
            chk("wait_busy", busy, 1);
        end
        for (int k = 0; k <= d; k++) begin
            @(negedge clk57);
            chk("bus_cyc", tx_cyc, oh);
            chk("bus_cur_chan", cur_chan, exp_g);
            if (k == d)                           tx_ack = oh;
            else if (spur >= 0 && spur != exp_g)  tx_ack = N'(1) << spur;
            else                                  tx_ack = '0;
        end
        @(negedge clk57);
        chk("done_cyc", tx_cyc, 0);
        chk("done_busy", busy, 1);
        chk("done_err", err_timeout, 0);
        tx_ack      = '0;
        fifo_nempty = '0;
        tx_empty    = '0;
        @(negedge clk57);
        chk("back_idle", busy, 0);
        ref_last = exp_g;
    endtask

    typedef struct {
        logic [N-1:0] ne;
        logic [N-1:0] te;
        int           exp_g;
        int           d;
        int           spur;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int order[3];
        tbl[0] = '{9'h001, 9'h1FF,  0, 2, -1};
        tbl[1] = '{9'h000, 9'h1FF, -1, 0, -1};
        tbl[2] = '{9'h008, 9'h1F7, -1, 0, -1};
        tbl[3] = '{9'h008, 9'h1FF,  3, 0, -1};
        tbl[4] = '{9'h1FF, 9'h1FF,  4, 3,  6};
        tbl[5] = '{9'h003, 9'h1FF,  0, 1, -1};
        tbl[6] = '{9'h003, 9'h1FF,  1, 0, -1};
        tbl[7] = '{9'h100, 9'h100,  8, 1, -1};
        tbl[8] = '{9'h1FF, 9'h1FF,  0, 0, -1};
        tbl[9] = '{9'h0C0, 9'h040,  6, 0, -1};

        do_reset();
        foreach (tbl[i]) xfer(tbl[i].ne, tbl[i].te, tbl[i].exp_g, tbl[i].d, tbl[i].spur, 1'b0);

        // Channels 2, 5, 8 always requesting, immediate acks.
        do_reset();
        order = '{2, 5, 8};
        prev  = 0;
        for (int r = 0; r < 6; r++) begin
            xfer(9'h124, 9'h1FF, order[r % 3], 0, -1, 1'b0);
            if (r > 0) chk("rr_spacing", last_rd_cyc - prev, 4 + RDLAT);
            prev = last_rd_cyc;
        end

        // Reset in WAIT discards the transfer and restores channel 0 priority.
        do_reset();
        fifo_nempty = 9'h020;
        tx_empty    = 9'h1FF;
        exp_q.push_back(9'h020);
        @(negedge clk57);
        chk("midrst_rd", fifo_rd, 9'h020);
        @(negedge clk57);
        chk("midrst_wait_busy", busy, 1);
        rst = 1'b1;
        fifo_nempty = 9'h003;
        @(negedge clk57);
        chk("midrst_rd0", fifo_rd, 0);
        chk("midrst_cyc0", tx_cyc, 0);
        chk("midrst_busy0", busy, 0);
        chk("midrst_chan0", cur_chan, 0);
        chk("midrst_err0", err_timeout, 0);
        rst = 1'b0;
        exp_q.delete();
        ref_last = N - 1;
        xfer(9'h003, 9'h1FF, 0, 0, -1, 1'b0);
        xfer(9'h003, 9'h1FF, 1, 0, -1, 1'b0);

        // Withheld ack.
        do_reset();
        fifo_nempty = 9'h002;
        tx_empty    = 9'h1FF;
        exp_q.push_back(9'h002);
        @(negedge clk57);
        chk("tmo_rd", fifo_rd, 9'h002);
        repeat (RDLAT) @(negedge clk57);
`ifdef GRID_SCHED_TIMEOUT_EN
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk57);
            chk("tmo_bus", tx_cyc, 9'h002);
            chk("tmo_err_low", err_timeout, 0);
        end
        @(negedge clk57);
        chk("tmo_drop", tx_cyc, 0);
        chk("tmo_err_pulse", err_timeout, 1);
        fifo_nempty = '0;
        @(negedge clk57);
        chk("tmo_err_once", err_timeout, 0);
        chk("tmo_idle", busy, 0);
        ref_last = 1;
        xfer(9'h003, 9'h1FF, 0, 1, -1, 1'b0);
`else
        repeat (1000) begin
            @(negedge clk57);
            chk("hang_bus", tx_cyc, 9'h002);
        end
        tx_ack = 9'h002;
        @(negedge clk57);
        chk("hang_done", tx_cyc, 0);
        tx_ack      = '0;
        fifo_nempty = '0;
        @(negedge clk57);
        chk("hang_idle", busy, 0);
        ref_last = 1;
`endif

        // Random requests checked against the round-robin rule.
        do_reset();
        repeat (40) begin
            logic [N-1:0] ne, te;
            int g;
            ne = N'($urandom);
            te = N'($urandom) | N'($urandom);
            g  = ref_grant(ne & te, ref_last);
            xfer(ne, te, g, $urandom_range(0, 3), $urandom_range(0, N - 1), 1'b1);
        end

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
